reaction_timer: RTL and testbench
=================================

// Module: reaction_timer
// PURPOSE
//   Measures player reaction time in milliseconds. After arming, waits for the stimulus level
//   from the random-delay countdown, then counts 1 ms ticks until the player presses stop.
//   Flags false starts and timeouts, and keeps the best time. Sits between the delay counter
//   (stimulus source) and the 7-segment display driver (consumes BCD outputs).
// PARAMETERS
//   TICK_DIV  50000  clock1 cycles per 1 ms tick (50 MHz board); simulations use 4
// PORTS
//   clock1        in   1   system clock, all state on posedge
//   reset         in   1   asynchronous, active-high; clears all state
//   start_key     in   1   arm request, synchronous level, rising edge used
//   stop_key      in   1   player response, synchronous level, rising edge used
//   stimulus      in   1   high when the random delay has expired (level)
//   led           out  1   1 while in TIMING
//   ms_bcd        out  16  current/last time, 4 BCD digits [15:12]=thousands
//   best_bcd      out  16  best valid time since reset, BCD
//   done          out  1   1 in DONE (valid result latched)
//   false_start   out  1   1 in FAULT caused by early stop
//   timeout       out  1   1 in FAULT caused by reaching 9999 ms
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high; clock port is clock1, reset port is reset.
//   Reset: state=IDLE, led=0, ms_bcd=0, best_bcd=16'h9999, done=0, false_start=0, timeout=0,
//     prescaler=0, key history registers=1 (a key held through reset gives no edge).
//   Edge detect: rise = key & ~key_q, key_q registered each cycle. The FSM acts in the same
//     cycle rise is high, so its outputs change one clock after the key's first high sample.
//   States:
//     IDLE      : start rise -> WAIT_STIM, ms_bcd<=0.
//     WAIT_STIM : stop rise -> FAULT, false_start<=1 (priority over stimulus in the same cycle).
//                 Else stimulus==1 -> TIMING, prescaler<=0, led<=1.
//     TIMING    : prescaler counts 0..TICK_DIV-1. Tick = cycle where prescaler==TICK_DIV-1.
//                 Prescaler wraps to 0 on tick. On tick, ms_bcd increments as decimal
//                 (digit 9 -> 0 with carry, no hex codes).
//                 stop rise -> DONE, led<=0, done<=1, ms_bcd held. Stop has priority:
//                   a tick in the same cycle is discarded.
//                 If ms_bcd==9999 and a tick occurs with no stop -> FAULT, timeout<=1,
//                   led<=0, ms_bcd stays 9999 (no wrap to 0000).
//                 stimulus dropping during TIMING is ignored.
//     DONE      : on entry, if ms_bcd < best_bcd (BCD compare == binary compare on packed
//                 digits), best_bcd<=ms_bcd. An equal value does not update.
//                 start rise -> WAIT_STIM, clear done, ms_bcd<=0.
//     FAULT     : best_bcd unchanged. start rise -> WAIT_STIM, clear both flags, ms_bcd<=0.
//   start rise in WAIT_STIM/TIMING is ignored. Only one of done/false_start/timeout is set at a time.
//   Reset mid-operation: immediate return to reset values, including best_bcd=9999.
//   All outputs are registered. No combinational path from inputs to outputs.
// TESTING (TICK_DIV=4)
//   reset; start rise; stimulus=1; stop rise after 10 ticks -> done=1, ms_bcd=16'h0010, best=0010
//   second run stopping after 7 ticks -> best_bcd=16'h0007; third run at 12 -> best stays 0007
//   start rise, stop rise before stimulus -> false_start=1, led=0, ms_bcd=0, best unchanged
//   stimulus=1, no stop -> ms_bcd reaches 16'h9999, next tick timeout=1 and ms_bcd stays 9999
//   count 9 -> 10 and 99 -> 100 -> ms_bcd 0009->0010, 0099->0100, never 000A
//   stop rise on a tick cycle -> count excludes that tick; assert reset mid-TIMING -> all reset values

Source files
------------

// File: rtl/reaction_timer.sv
// Purpose: measures the delay from stimulus to stop press in BCD milliseconds, tracking false starts, timeouts and best time.
// Latency: all outputs are registered and change one clock after the first high sample of a key or stimulus.
// Backpressure: none; keys and stimulus are sampled levels, and a key must fall and rise again to be seen twice.
module reaction_timer #(
   parameter int TICK_DIV = 50000
) (
   input  logic        clock1,
   input  logic        reset,
   input  logic        start_key,
   input  logic        stop_key,
   input  logic        stimulus,
   output logic        led,
   output logic [15:0] ms_bcd,
   output logic [15:0] best_bcd,
   output logic        done,
   output logic        false_start,
   output logic        timeout
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [15:0] MS_MAX = 16'h9999;

   typedef enum logic [2:0] {IDLE, WAIT_STIM, TIMING, DONE, FAULT} state_t;

   state_t          state, state_nxt;
   logic            start_q, stop_q;
   logic            start_rise, stop_rise, tick;
   logic [PW-1:0]   prescaler, prescaler_nxt;
   logic [15:0]     ms_nxt, best_nxt;
   logic            led_nxt, done_nxt, false_start_nxt, timeout_nxt;

   // Decimal increment of four packed BCD digits; 9 rolls to 0 and carries upward.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign start_rise = start_key & ~start_q;
   assign stop_rise  = stop_key & ~stop_q;
   assign tick       = (state == TIMING) && (prescaler == TICK_LAST);

   // Key history; held high in reset so a key held through reset produces no edge.
   always_ff @(posedge clock1 or posedge reset) begin
      if (reset) begin
         start_q <= 1'b1;
         stop_q  <= 1'b1;
      end else begin
         start_q <= start_key;
         stop_q  <= stop_key;
      end
   end

   // State register.
   always_ff @(posedge clock1 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode; stop always beats stimulus or a coincident tick.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_rise) state_nxt = WAIT_STIM;
         WAIT_STIM: begin
            if (stop_rise)     state_nxt = FAULT;
            else if (stimulus) state_nxt = TIMING;
         end
         TIMING: begin
            if (stop_rise)                        state_nxt = DONE;
            else if (tick && (ms_bcd == MS_MAX)) state_nxt = FAULT;
         end
         DONE:      if (start_rise) state_nxt = WAIT_STIM;
         FAULT:     if (start_rise) state_nxt = WAIT_STIM;
         default:   state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and the tick prescaler.
   always_comb begin
      ms_nxt          = ms_bcd;
      best_nxt        = best_bcd;
      led_nxt         = led;
      done_nxt        = done;
      false_start_nxt = false_start;
      timeout_nxt     = timeout;
      prescaler_nxt   = '0;
      case (state)
         IDLE: if (start_rise) ms_nxt = 16'h0000;
         WAIT_STIM: begin
            if (stop_rise)     false_start_nxt = 1'b1;
            else if (stimulus) led_nxt         = 1'b1;
         end
         TIMING: begin
            if (stop_rise) begin
               // Result is final here, so the best-time compare happens on DONE entry.
               led_nxt  = 1'b0;
               done_nxt = 1'b1;
               if (ms_bcd < best_bcd) best_nxt = ms_bcd;
            end else if (tick) begin
               if (ms_bcd == MS_MAX) begin
                  timeout_nxt = 1'b1;
                  led_nxt     = 1'b0;
               end else begin
                  ms_nxt = bcd_inc(ms_bcd);
               end
            end else begin
               prescaler_nxt = prescaler + 1'b1;
            end
         end
         DONE: begin
            if (start_rise) begin
               done_nxt = 1'b0;
               ms_nxt   = 16'h0000;
            end
         end
         FAULT: begin
            if (start_rise) begin
               false_start_nxt = 1'b0;
               timeout_nxt     = 1'b0;
               ms_nxt          = 16'h0000;
            end
         end
         default: ;
      endcase
   end

   // Output and prescaler registers.
   always_ff @(posedge clock1 or posedge reset) begin
      if (reset) begin
         prescaler   <= '0;
         led         <= 1'b0;
         ms_bcd      <= 16'h0000;
         best_bcd    <= MS_MAX;
         done        <= 1'b0;
         false_start <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         prescaler   <= prescaler_nxt;
         led         <= led_nxt;
         ms_bcd      <= ms_nxt;
         best_bcd    <= best_nxt;
         done        <= done_nxt;
         false_start <= false_start_nxt;
         timeout     <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with TICK_DIV=4: best-time tracking, BCD carries,
// false start, stop-on-tick priority, timeout at 9999 and asynchronous reset.
module tb_reaction_timer;

   logic        clock1 = 1'b0;
   logic        reset = 1'b0;
   logic        start_key = 1'b0;
   logic        stop_key = 1'b0;
   logic        stimulus = 1'b0;
   logic        led;
   logic [15:0] ms_bcd;
   logic [15:0] best_bcd;
   logic        done;
   logic        false_start;
   logic        timeout;

   int errors = 0;
   int checks = 0;

   reaction_timer #(.TICK_DIV(4)) dut (
      .clock1      (clock1),
      .reset       (reset),
      .start_key   (start_key),
      .stop_key    (stop_key),
      .stimulus    (stimulus),
      .led         (led),
      .ms_bcd      (ms_bcd),
      .best_bcd    (best_bcd),
      .done        (done),
      .false_start (false_start),
      .timeout     (timeout)
   );

   always #5 clock1 = ~clock1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock1);
   endtask

   // Start rise plus stimulus: after return the DUT is in TIMING with prescaler 0.
   task automatic start_run();
      start_key = 1'b1;
      step(1);
      start_key = 1'b0;
      stimulus  = 1'b1;
      step(1);
   endtask

   task automatic stop_run();
      stop_key = 1'b1;
      step(1);
      stop_key = 1'b0;
      stimulus = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      start_key = 1'b1;
      reset = 1'b1;
      #1;
      checks++;
      if ({led, done, false_start, timeout} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {led, done, false_start, timeout});
      end
      checks++;
      if (ms_bcd !== 16'h0000) begin
         errors++;
         $display("FAIL reset_ms: got %h expected 0000", ms_bcd);
      end
      checks++;
      if (best_bcd !== 16'h9999) begin
         errors++;
         $display("FAIL reset_best: got %h expected 9999", best_bcd);
      end
      step(2);
      reset = 1'b0;
      step(2);
      // start held through reset must not arm: stimulus now must not light the led
      stimulus = 1'b1;
      step(2);
      checks++;
      if (led !== 1'b0) begin
         errors++;
         $display("FAIL held_key_no_edge: led got %b expected 0", led);
      end
      stimulus  = 1'b0;
      start_key = 1'b0;
      step(2);
   endtask

   task automatic test_first_run();
      start_run();
      checks++;
      if (led !== 1'b1) begin
         errors++;
         $display("FAIL run10_led: got %b expected 1", led);
      end
      step(40);
      stop_run();
      checks++;
      if ({done, led} !== 2'b10) begin
         errors++;
         $display("FAIL run10_done_led: got %b expected 10", {done, led});
      end
      checks++;
      if (ms_bcd !== 16'h0010) begin
         errors++;
         $display("FAIL run10_ms: got %h expected 0010", ms_bcd);
      end
      checks++;
      if (best_bcd !== 16'h0010) begin
         errors++;
         $display("FAIL run10_best: got %h expected 0010", best_bcd);
      end
   endtask

   task automatic test_best_tracking();
      start_key = 1'b1;
      step(1);
      start_key = 1'b0;
      checks++;
      if ({done, ms_bcd} !== {1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL rearm_clear: done/ms got %b/%h expected 0/0000", done, ms_bcd);
      end
      stimulus = 1'b1;
      step(1);
      step(28);
      stop_run();
      checks++;
      if ({ms_bcd, best_bcd} !== {16'h0007, 16'h0007}) begin
         errors++;
         $display("FAIL run7: ms/best got %h/%h expected 0007/0007", ms_bcd, best_bcd);
      end
      // third run at 12 with an ignored start pulse mid-timing
      start_run();
      step(12);
      start_key = 1'b1;
      step(1);
      start_key = 1'b0;
      step(35);
      checks++;
      if ({led, ms_bcd} !== {1'b1, 16'h0012}) begin
         errors++;
         $display("FAIL start_ignored: led/ms got %b/%h expected 1/0012", led, ms_bcd);
      end
      stop_run();
      checks++;
      if ({done, ms_bcd, best_bcd} !== {1'b1, 16'h0012, 16'h0007}) begin
         errors++;
         $display("FAIL run12: done/ms/best got %b/%h/%h expected 1/0012/0007", done, ms_bcd, best_bcd);
      end
   endtask

   task automatic test_bcd_carry();
      start_run();
      stimulus = 1'b0;  // dropping stimulus during timing is ignored
      step(36);
      checks++;
      if (ms_bcd !== 16'h0009) begin
         errors++;
         $display("FAIL carry_9: got %h expected 0009", ms_bcd);
      end
      step(4);
      checks++;
      if (ms_bcd !== 16'h0010) begin
         errors++;
         $display("FAIL carry_10: got %h expected 0010", ms_bcd);
      end
      step(356);
      checks++;
      if ({led, ms_bcd} !== {1'b1, 16'h0099}) begin
         errors++;
         $display("FAIL carry_99: led/ms got %b/%h expected 1/0099", led, ms_bcd);
      end
      step(4);
      checks++;
      if (ms_bcd !== 16'h0100) begin
         errors++;
         $display("FAIL carry_100: got %h expected 0100", ms_bcd);
      end
      stop_run();
      checks++;
      if ({ms_bcd, best_bcd} !== {16'h0100, 16'h0007}) begin
         errors++;
         $display("FAIL run100: ms/best got %h/%h expected 0100/0007", ms_bcd, best_bcd);
      end
   endtask

   task automatic test_false_start();
      start_key = 1'b1;
      step(1);
      start_key = 1'b0;
      step(3);
      stop_key = 1'b1;
      step(1);
      stop_key = 1'b0;
      checks++;
      if ({false_start, done, timeout, led} !== 4'b1000) begin
         errors++;
         $display("FAIL false_start_flags: got %b expected 1000", {false_start, done, timeout, led});
      end
      checks++;
      if ({ms_bcd, best_bcd} !== {16'h0000, 16'h0007}) begin
         errors++;
         $display("FAIL false_start_ms_best: got %h/%h expected 0000/0007", ms_bcd, best_bcd);
      end
      // re-arm from FAULT, then stop and stimulus in the same cycle: stop wins
      start_key = 1'b1;
      step(1);
      start_key = 1'b0;
      checks++;
      if (false_start !== 1'b0) begin
         errors++;
         $display("FAIL fault_rearm_clear: got %b expected 0", false_start);
      end
      stop_key = 1'b1;
      stimulus = 1'b1;
      step(1);
      stop_key = 1'b0;
      stimulus = 1'b0;
      step(2);
      checks++;
      if ({false_start, led} !== 2'b10) begin
         errors++;
         $display("FAIL stop_beats_stimulus: fs/led got %b expected 10", {false_start, led});
      end
   endtask

   task automatic test_stop_on_tick();
      start_run();
      step(32);
      step(3);          // next posedge carries the 9th tick
      stop_key = 1'b1;
      step(1);
      stop_key = 1'b0;
      stimulus = 1'b0;
      checks++;
      if ({done, ms_bcd, best_bcd} !== {1'b1, 16'h0008, 16'h0007}) begin
         errors++;
         $display("FAIL stop_on_tick: done/ms/best got %b/%h/%h expected 1/0008/0007", done, ms_bcd, best_bcd);
      end
   endtask

   task automatic test_timeout();
      start_run();
      step(9999 * 4);
      checks++;
      if ({led, timeout, ms_bcd} !== {1'b1, 1'b0, 16'h9999}) begin
         errors++;
         $display("FAIL at_9999: led/to/ms got %b/%b/%h expected 1/0/9999", led, timeout, ms_bcd);
      end
      step(3);
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got %b expected 0", timeout);
      end
      step(1);
      checks++;
      if ({timeout, led, done, false_start} !== 4'b1000) begin
         errors++;
         $display("FAIL timeout_flags: got %b expected 1000", {timeout, led, done, false_start});
      end
      step(8);
      checks++;
      if ({ms_bcd, best_bcd} !== {16'h9999, 16'h0007}) begin
         errors++;
         $display("FAIL timeout_hold: ms/best got %h/%h expected 9999/0007", ms_bcd, best_bcd);
      end
      stimulus = 1'b0;
   endtask

   task automatic test_reset_mid_timing();
      start_run();
      step(21);
      checks++;
      if ({led, ms_bcd} !== {1'b1, 16'h0005}) begin
         errors++;
         $display("FAIL pre_reset_timing: led/ms got %b/%h expected 1/0005", led, ms_bcd);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({led, done, false_start, timeout, ms_bcd, best_bcd} !== {4'b0000, 16'h0000, 16'h9999}) begin
         errors++;
         $display("FAIL mid_reset: flags/ms/best got %b/%h/%h expected 0000/0000/9999",
                  {led, done, false_start, timeout}, ms_bcd, best_bcd);
      end
      step(2);
      reset    = 1'b0;
      stimulus = 1'b0;
      step(2);
      checks++;
      if ({led, ms_bcd} !== {1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL post_reset_idle: led/ms got %b/%h expected 0/0000", led, ms_bcd);
      end
   endtask

   initial begin
      step(1);
      test_reset();
      test_first_run();
      test_best_tracking();
      test_bcd_carry();
      test_false_start();
      test_stop_on_tick();
      test_timeout();
      test_reset_mid_timing();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
